// File: rtl/fuel_pkg.sv
// Shared types and seven-segment constants for the BCD fuel meter.
// Segment codes are active-high in gfedcba bit order.
package fuel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } fuel_state_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Non-decimal nibbles show nothing rather than a misleading glyph.
  function automatic logic [6:0] seg_code(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_code = SEG_0;
      4'd1:    seg_code = SEG_1;
      4'd2:    seg_code = SEG_2;
      4'd3:    seg_code = SEG_3;
      4'd4:    seg_code = SEG_4;
      4'd5:    seg_code = SEG_5;
      4'd6:    seg_code = SEG_6;
      4'd7:    seg_code = SEG_7;
      4'd8:    seg_code = SEG_8;
      4'd9:    seg_code = SEG_9;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_seg7.sv
// Purely combinational single-digit BCD to seven-segment decoder with blanking.
module bcd_seg7
  import fuel_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = blank ? SEG_BLANK : seg_code(digit);
  end

endmodule

// File: rtl/fuel_meter_bcd.sv
// Fuel pump cost meter: counts a BCD value up to a latched target at a
// prescaled rate, with pause/abort control and a leading-zero-blanked display.
module fuel_meter_bcd
  import fuel_pkg::*;
#(
  parameter int N_DIGITS = 3,
  parameter int TICK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  pause,
  input  logic                  blank_lz,
  input  logic [4*N_DIGITS-1:0] target_bcd,
  output logic [4*N_DIGITS-1:0] count_bcd,
  output logic [7*N_DIGITS-1:0] seg,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int         W         = 4 * N_DIGITS;
  localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

  fuel_state_t    state, state_next;
  logic [W-1:0]   count, count_next, count_inc;
  logic [W-1:0]   target_q, target_next;
  logic [7:0]     presc, presc_next;
  logic           err_q, err_next;
  logic           target_valid;
  logic [N_DIGITS-1:0] blank_vec;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      count    <= '0;
      target_q <= '0;
      presc    <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      target_q <= target_next;
      presc    <= presc_next;
      err_q    <= err_next;
    end
  end

  always_comb begin
    target_valid = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (target_bcd[4*i +: 4] > 4'd9) target_valid = 1'b0;
    end
  end

  // Decimal ripple increment; the all-nines case cannot occur below a valid target.
  always_comb begin
    logic carry;
    carry     = 1'b1;
    count_inc = count;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (carry) begin
        if (count[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_next  = state;
    count_next  = count;
    target_next = target_q;
    presc_next  = presc;
    err_next    = err_q;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (target_valid) begin
            target_next = target_bcd;
            count_next  = '0;
            presc_next  = '0;
            err_next    = 1'b0;
            state_next  = ST_RUN;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (count == target_q) begin
          state_next = ST_DONE;
        end else if (pause) begin
          state_next = ST_PAUSE;
        end else if (presc == TICK_LAST) begin
          count_next = count_inc;
          presc_next = '0;
        end else begin
          presc_next = presc + 8'd1;
        end
      end
      ST_PAUSE: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (!pause) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A digit is blanked only if it and every digit above it are zero.
  always_comb begin
    logic higher_zero;
    higher_zero = 1'b1;
    blank_vec   = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      higher_zero  = higher_zero && (count[4*i +: 4] == 4'd0);
      blank_vec[i] = blank_lz && higher_zero && (i != 0);
    end
  end

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
    bcd_seg7 u_seg (
      .digit (count[4*g +: 4]),
      .blank (blank_vec[g]),
      .seg   (seg[7*g +: 7])
    );
  end

  assign count_bcd = count;
  assign err       = err_q;
  assign busy      = (state == ST_RUN) || (state == ST_PAUSE);
  assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_fuel_meter_bcd.sv
// Directed bench for fuel_meter_bcd: a default instance plus a TICK_DIV=1
// instance for the decimal carry case.
module tb_fuel_meter_bcd;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, abort, pause, blank_lz;
  logic [11:0] target_bcd;
  logic [11:0] count_bcd;
  logic [20:0] seg;
  logic        busy, done, err;

  logic        f_start;
  logic        f_tie0;
  logic [11:0] f_target;
  logic [11:0] f_count;
  logic [20:0] f_seg;
  logic        f_busy, f_done, f_err;

  int checks   = 0;
  int failures = 0;
  int n;

  localparam logic [20:0] SEG_000       = {7'h3F, 7'h3F, 7'h3F};
  localparam logic [20:0] SEG_000_BLANK = {7'h00, 7'h00, 7'h3F};
  localparam logic [20:0] SEG_007       = {7'h3F, 7'h3F, 7'h07};
  localparam logic [20:0] SEG_007_BLANK = {7'h00, 7'h00, 7'h07};

  fuel_meter_bcd dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .pause      (pause),
    .blank_lz   (blank_lz),
    .target_bcd (target_bcd),
    .count_bcd  (count_bcd),
    .seg        (seg),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  fuel_meter_bcd #(.N_DIGITS(3), .TICK_DIV(1)) dut_fast (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (f_start),
    .abort      (f_tie0),
    .pause      (f_tie0),
    .blank_lz   (f_tie0),
    .target_bcd (f_target),
    .count_bcd  (f_count),
    .seg        (f_seg),
    .busy       (f_busy),
    .done       (f_done),
    .err        (f_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] tgt);
    target_bcd = tgt;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int edges);
    edges = 0;
    while (!done && edges < budget) begin
      tick();
      edges++;
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; pause = 1'b0; blank_lz = 1'b0;
    target_bcd = 12'h000; f_start = 1'b0; f_tie0 = 1'b0; f_target = 12'h000;
    tick(); tick();
    reset_n = 1'b1;
    checkOutput("reset_busy",  busy, 0);
    checkOutput("reset_done",  done, 0);
    checkOutput("reset_err",   err, 0);
    checkOutput("reset_count", count_bcd, 12'h000);
    checkOutput("reset_seg",   seg, SEG_000);
    checkOutput("reset_fast_count", f_count, 12'h000);

    // Target 012 at divide-by-4: DONE 49 edges after the start edge.
    applyStimulus(12'h012);
    checkOutput("run_busy", busy, 1);
    repeat (3) tick();
    checkOutput("run_count_e3", count_bcd, 12'h000);
    tick();
    checkOutput("run_count_e4", count_bcd, 12'h001);
    waitDone(200, n);
    checkOutput("run_done_edges", 4 + n, 49);
    checkOutput("run_done",   done, 1);
    checkOutput("run_busy_off", busy, 0);
    checkOutput("run_count",  count_bcd, 12'h012);
    checkOutput("run_seg_d0", seg[6:0], 7'h5B);
    checkOutput("run_seg_d1", seg[13:7], 7'h06);
    repeat (3) tick();
    checkOutput("done_hold", done, 1);
    checkOutput("done_hold_count", count_bcd, 12'h012);

    // Pause freezes 10 edges: entry edge, 8 holding edges, exit edge.
    applyStimulus(12'h012);
    repeat (5) tick();
    pause = 1'b1;
    repeat (9) tick();
    checkOutput("pause_count", count_bcd, 12'h001);
    checkOutput("pause_presc", dut.presc, 1);
    checkOutput("pause_busy",  busy, 1);
    pause = 1'b0;
    waitDone(200, n);
    checkOutput("pause_done_edges", 14 + n, 59);

    // Abort at 005 from DONE-restart.
    applyStimulus(12'h012);
    repeat (20) tick();
    checkOutput("abort_pre_count", count_bcd, 12'h005);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_busy",  busy, 0);
    checkOutput("abort_done",  done, 0);
    checkOutput("abort_count", count_bcd, 12'h005);

    applyStimulus(12'h012);
    checkOutput("restart_count", count_bcd, 12'h000);
    checkOutput("restart_busy",  busy, 1);
    repeat (3) tick();
    applyStimulus(12'h0A3);
    checkOutput("run_start_ignored_err", err, 0);
    checkOutput("run_start_ignored_cnt", count_bcd, 12'h001);
    repeat (24) tick();
    checkOutput("count_007", count_bcd, 12'h007);
    checkOutput("seg_007", seg, SEG_007);
    blank_lz = 1'b1;
    #1;
    checkOutput("seg_007_blank", seg, SEG_007_BLANK);

    // Reset mid-run wins over a simultaneous start.
    reset_n = 1'b0;
    start = 1'b1;
    target_bcd = 12'h012;
    tick();
    start = 1'b0;
    reset_n = 1'b1;
    checkOutput("midreset_busy",  busy, 0);
    checkOutput("midreset_count", count_bcd, 12'h000);
    checkOutput("midreset_seg_blank", seg, SEG_000_BLANK);
    blank_lz = 1'b0;

    // Invalid target then valid target 003.
    applyStimulus(12'h0A3);
    checkOutput("bad_err",  err, 1);
    checkOutput("bad_busy", busy, 0);
    checkOutput("bad_count", count_bcd, 12'h000);
    applyStimulus(12'h003);
    checkOutput("good_err", err, 0);
    waitDone(100, n);
    checkOutput("good_done_edges", n, 13);
    checkOutput("good_count", count_bcd, 12'h003);

    // Carry 099 -> 100 with divide-by-1: DONE 101 edges after start.
    f_target = 12'h100;
    f_start  = 1'b1;
    tick();
    f_start  = 1'b0;
    repeat (99) tick();
    checkOutput("fast_count_099", f_count, 12'h099);
    checkOutput("fast_done_e99", f_done, 0);
    tick();
    checkOutput("fast_count_100", f_count, 12'h100);
    checkOutput("fast_done_e100", f_done, 0);
    tick();
    checkOutput("fast_done_e101", f_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fuel_meter_bcd.md
FUEL_METER_BCD -- requirements
Module: fuel_meter_bcd

Interface
REQ-001 SHALL have parameter N_DIGITS, default 3, meaning the number of BCD display digits (legal range 1..6).
REQ-002 SHALL have parameter TICK_DIV, default 4, meaning the clock cycles per count increment (legal range 1..255).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: begin a dispense run.
REQ-006 SHALL have port abort, input, 1 bit: cancel a run in progress.
REQ-007 SHALL have port pause, input, 1 bit: level input that freezes counting while high.
REQ-008 SHALL have port blank_lz, input, 1 bit: blank leading-zero digits when high.
REQ-009 SHALL have port target_bcd, input, 4*N_DIGITS bits: packed BCD final cost, with digit 0 in the LSBs.
REQ-010 SHALL have port count_bcd, output, 4*N_DIGITS bits: packed BCD current value.
REQ-011 SHALL have port seg, output, 7*N_DIGITS bits: active-high segments in bit order gfedcba, with digit 0 in the LSBs.
REQ-012 SHALL have port busy, output, 1 bit: high while in RUN or PAUSE.
REQ-013 SHALL have port done, output, 1 bit: high while in DONE.
REQ-014 SHALL have port err, output, 1 bit: sticky flag for an invalid target.

Function
REQ-015 SHALL implement states IDLE, RUN, PAUSE and DONE.
REQ-016 SHALL, in IDLE or DONE on start=1 with a valid target, latch target_bcd, clear count and the prescaler, clear err, and enter RUN at the next edge.
REQ-017 SHALL treat a target as valid only if every digit is at most 9.
REQ-018 SHALL, on start=1 with an invalid target, keep the current state, leave count unchanged, and set err=1.
REQ-019 SHALL, at each RUN edge, apply the following in priority order: abort; then count==latched target leads to DONE; then pause leads to PAUSE; otherwise prescaler action.
REQ-020 SHALL define prescaler action as: if prescaler==TICK_DIV-1, count increments by 1 in BCD and prescaler goes to 0; otherwise prescaler increments by 1.
REQ-021 SHALL make BCD increment ripple digit carries so that a 9 becomes 0 and carries into the next digit; this never overflows because the target is at most all-9s.
REQ-022 SHALL, for target T (binary value) and divider D, enter DONE exactly T*D+1 edges after the edge that sampled start.
REQ-023 SHALL, for T=0, enter DONE at the second edge after start.
REQ-024 SHALL, in PAUSE, hold both count and prescaler.
REQ-025 SHALL, in PAUSE, go to IDLE on abort=1, return to RUN on pause=0, and otherwise stay in PAUSE.
REQ-026 SHALL, on abort in RUN or PAUSE, enter IDLE with count retained for display and done=0.
REQ-027 SHALL ignore start while in RUN or PAUSE.
REQ-028 SHALL hold DONE with count equal to target until start; there is no automatic return to IDLE.
REQ-029 SHALL drive seg per digit combinationally from count_bcd using the codes 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F (hex, gfedcba).
REQ-030 SHALL, when blank_lz=1, drive seg=0 for every zero digit above the most-significant nonzero digit; digit 0 is never blanked.
REQ-031 SHALL derive busy and done combinationally from the state register only.

Reset
REQ-032 SHALL, when reset_n=0 at a rising clk edge, set state to IDLE, count to 0, prescaler to 0, latched target to 0 and err to 0.
REQ-033 SHALL, after reset, present busy=0, done=0, err=0, count_bcd=0, and seg showing all zeros (digit 0 = 3F, with higher digits 3F or blanked per blank_lz).
REQ-034 SHALL give reset priority over start, abort and pause, including mid-run.

Structure
REQ-035 SHALL place in package fuel_pkg the state enum fuel_state_t, the segment-code constants, and the blank code (7'h00).
REQ-036 SHALL use sub-module bcd_seg7: a combinational 4-bit digit plus blank input producing a 7-bit segment output, instantiated N_DIGITS times through a generate loop.
REQ-037 SHALL keep all state in the top module; bcd_seg7 SHALL contain no registers.

Verification
REQ-038 SHALL cover default parameters with target 012 and start pulsed for 1 cycle: busy high, count advances every 4 cycles, DONE entered 49 edges after start, count_bcd=012, seg digit0=5B, digit1=06.
REQ-039 SHALL cover the carry case target 100 with TICK_DIV=1: count steps 099 to 100 in one edge, and done asserts after 101 edges.
REQ-040 SHALL cover pause high for 10 cycles mid-run: count and prescaler are frozen, and total time to done grows by exactly 10 cycles.
REQ-041 SHALL cover abort at count 005: the block is in IDLE next edge, count_bcd stays 005, done=0, and a following start restarts from 000.
REQ-042 SHALL cover start with target 0A3: err=1 and the state stays IDLE; a following start with target 003 clears err and reaches done after 13 edges.
REQ-043 SHALL cover blank_lz=1 with count 007 and N_DIGITS=3: seg reads {00,00,07}; with reset_n=0 mid-run, the next edge gives IDLE and count 000.
